// File: rtl/csr_rmw_pkg.sv
// csr_rmw_pkg: shared definitions for the Zicsr read-modify-write controller.
//   - XLEN and the CSR_ADDR_NONE sentinel ("no CSR access")
//   - funct3 encodings of the six Zicsr instructions
//   - FSM state encoding
//   - common machine-mode CSR addresses
//   - latched-op record and small decode helpers
package csr_rmw_pkg;

    localparam int          XLEN          = 32;
    localparam logic [11:0] CSR_ADDR_NONE = 12'hFFF;

    // funct3[2] selects the immediate form; funct3[1:0] selects W/S/C.
    localparam logic [2:0] F3_RW  = 3'b001;
    localparam logic [2:0] F3_RS  = 3'b010;
    localparam logic [2:0] F3_RC  = 3'b011;
    localparam logic [2:0] F3_RWI = 3'b101;
    localparam logic [2:0] F3_RSI = 3'b110;
    localparam logic [2:0] F3_RCI = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_WCSR = 2'd2;
    localparam logic [1:0] ST_WRD  = 2'd3;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;

    typedef struct packed {
        logic [2:0]      funct3;
        logic [11:0]     addr;
        logic [XLEN-1:0] src;
        logic [4:0]      rd;
        logic [4:0]      rs1;
    } csr_op_t;

    // W forms always write; S/C forms write only with a nonzero rs1 index/uimm.
    function automatic logic op_writes(input logic [2:0] funct3, input logic [4:0] rs1);
        return (funct3[1:0] == 2'b01) || (rs1 != 5'd0);
    endfunction

    function automatic logic csr_is_ro(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// csr_rmw_alu: combinational new-CSR-value computation.
//   funct3 in  3     Zicsr funct3 (only [1:0] matters: W/S/C)
//   old    in  XLEN  CSR value read before the write
//   src    in  XLEN  rs1 data or zero-extended uimm
//   result out XLEN  value to write back to the CSR
module csr_rmw_alu
    import csr_rmw_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] old,
    input  logic [XLEN-1:0] src,
    output logic [XLEN-1:0] result
);

    always_comb begin
        case (funct3[1:0])
            2'b10:   result = old | src;
            2'b11:   result = old & ~src;
            default: result = src;
        endcase
    end

endmodule

// File: rtl/csr_rmw_ctrl.sv
// csr_rmw_ctrl: sequences one Zicsr op as CSR read, CSR write, rd write.
// The register file favours rd writes over CSR writes, so the two writes
// occupy separate cycles. Outputs are decoded from the current state.
//   clk, rst                 clock, synchronous active-high reset
//   req_valid_i/req_ready_o  op handshake from decode (ready only when idle)
//   req_funct3_i, req_csr_addr_i, req_rs1_addr_i, req_rs1_data_i, req_rd_addr_i
//                            decoded op fields (rs1 index doubles as uimm)
//   csr_raddr_o/csr_rdata_i  CSR read port (combinational read data)
//   csr_waddr_o/csr_wdata_o  CSR write port, CSR_ADDR_NONE when not writing
//   rd_waddr_o/rd_wdata_o    rd write port, both zero when not writing
//   done_o, illegal_o        pulses in the final active cycle of an op
// Build option CSR_RMW_FASTWR_EN: RW/RWI with rd==0 skip READ and go straight
// to WCSR; the read-only check is done at accept.
module csr_rmw_ctrl
    import csr_rmw_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_funct3_i,
    input  logic [11:0]     req_csr_addr_i,
    input  logic [4:0]      req_rs1_addr_i,
    input  logic [XLEN-1:0] req_rs1_data_i,
    input  logic [4:0]      req_rd_addr_i,
    output logic [11:0]     csr_raddr_o,
    input  logic [XLEN-1:0] csr_rdata_i,
    output logic [11:0]     csr_waddr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic [4:0]      rd_waddr_o,
    output logic [XLEN-1:0] rd_wdata_o,
    output logic            done_o,
    output logic            illegal_o
);

    logic [1:0]      state, state_nxt;
    csr_op_t         op;
    logic [XLEN-1:0] old;
    logic [XLEN-1:0] new_val;
    logic            accept;
    logic            wcsr;
    logic            ro_fault;
    logic            fast_go;
    logic            fast_ill;

    assign accept   = req_valid_i && req_ready_o;
    assign wcsr     = op_writes(op.funct3, op.rs1);
    assign ro_fault = wcsr && csr_is_ro(op.addr);

`ifdef CSR_RMW_FASTWR_EN
    // W forms do not depend on the old value, so with no rd there is nothing to read.
    assign fast_go = (req_funct3_i[1:0] == 2'b01) && (req_rd_addr_i == 5'd0);
    always_ff @(posedge clk) begin
        if (rst)
            fast_ill <= 1'b0;
        else if (accept)
            fast_ill <= fast_go && csr_is_ro(req_csr_addr_i);
    end
`else
    assign fast_go  = 1'b0;
    assign fast_ill = 1'b0;
`endif

    csr_rmw_alu u_alu (
        .funct3 (op.funct3),
        .old    (old),
        .src    (op.src),
        .result (new_val)
    );

    always_comb begin
        state_nxt   = state;
        req_ready_o = 1'b0;
        csr_raddr_o = CSR_ADDR_NONE;
        csr_waddr_o = CSR_ADDR_NONE;
        csr_wdata_o = '0;
        rd_waddr_o  = 5'd0;
        rd_wdata_o  = '0;
        done_o      = 1'b0;
        illegal_o   = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i)
                    state_nxt = fast_go ? ST_WCSR : ST_READ;
            end
            ST_READ: begin
                // Write port stays at NONE so the regfile cannot forward into this read.
                csr_raddr_o = op.addr;
                if (ro_fault) begin
                    done_o    = 1'b1;
                    illegal_o = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (wcsr) begin
                    state_nxt = ST_WCSR;
                end else if (op.rd != 5'd0) begin
                    state_nxt = ST_WRD;
                end else begin
                    done_o    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_WCSR: begin
                if (fast_ill) begin
                    done_o    = 1'b1;
                    illegal_o = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    csr_waddr_o = op.addr;
                    csr_wdata_o = new_val;
                    if (op.rd != 5'd0) begin
                        state_nxt = ST_WRD;
                    end else begin
                        done_o    = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                rd_waddr_o = op.rd;
                rd_wdata_o = old;
                done_o     = 1'b1;
                state_nxt  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Datapath registers are only consumed after an accept, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op.funct3 <= req_funct3_i;
            op.addr   <= req_csr_addr_i;
            op.src    <= req_funct3_i[2] ? {{(XLEN-5){1'b0}}, req_rs1_addr_i} : req_rs1_data_i;
            op.rd     <= req_rd_addr_i;
            op.rs1    <= req_rs1_addr_i;
        end
        if (state == ST_READ)
            old <= csr_rdata_i;
    end

endmodule

// File: tb/tb_csr_rmw_ctrl.sv
// tb_csr_rmw_ctrl: self-checking bench for csr_rmw_ctrl. The bench also plays
// the CSR/register file. Directed vectors come from a table; random ops are
// checked cycle by cycle against a trace model built from the op semantics.
module tb_csr_rmw_ctrl;
    import csr_rmw_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_csr_addr;
    logic [4:0]  req_rs1_addr;
    logic [31:0] req_rs1_data;
    logic [4:0]  req_rd_addr;
    logic [11:0] csr_raddr, csr_waddr;
    logic [31:0] csr_rdata, csr_wdata;
    logic [4:0]  rd_waddr;
    logic [31:0] rd_wdata;
    logic        done, illegal;

    logic [31:0] csr_mem [0:4095];
    logic [31:0] rf [0:31];
    logic        rf_clr, pre_en;
    logic [11:0] pre_addr;
    logic [31:0] pre_data;

    int n_chk = 0;
    int n_fail = 0;

    csr_rmw_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_funct3_i(req_funct3), .req_csr_addr_i(req_csr_addr),
        .req_rs1_addr_i(req_rs1_addr), .req_rs1_data_i(req_rs1_data),
        .req_rd_addr_i(req_rd_addr),
        .csr_raddr_o(csr_raddr), .csr_rdata_i(csr_rdata),
        .csr_waddr_o(csr_waddr), .csr_wdata_o(csr_wdata),
        .rd_waddr_o(rd_waddr), .rd_wdata_o(rd_wdata),
        .done_o(done), .illegal_o(illegal)
    );

    always #5 clk = ~clk;

    assign csr_rdata = (csr_raddr == 12'hFFF) ? 32'h0 : csr_mem[csr_raddr];

    always @(posedge clk) begin
        if (rf_clr)
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
        else if (rd_waddr != 5'd0)
            rf[rd_waddr] <= rd_wdata;
        if (pre_en)
            csr_mem[pre_addr] <= pre_data;
        else if (csr_waddr != 12'hFFF)
            csr_mem[csr_waddr] <= csr_wdata;
    end

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [4:0]  rs1;
        logic [31:0] rs1_data;
        logic [4:0]  rd;
    } op_t;

    typedef struct {
        op_t         op;
        logic [31:0] init;
        logic [31:0] exp_csr;
        bit          chk_rd;
        logic [31:0] exp_rd;
        int          exp_len;
        bit          exp_ill;
    } vec_t;

    typedef struct {
        logic [11:0] raddr;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [4:0]  rdw;
        logic [31:0] rdd;
        logic        dn;
        logic        il;
    } cyc_t;

    cyc_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic op_t mkop(input logic [2:0] f3, input logic [11:0] addr,
                                 input logic [4:0] rs1, input logic [31:0] d, input logic [4:0] rd);
        op_t o;
        o.f3 = f3; o.addr = addr; o.rs1 = rs1; o.rs1_data = d; o.rd = rd;
        return o;
    endfunction

    function automatic vec_t mk(input op_t o, input logic [31:0] init, input logic [31:0] ecsr,
                                input bit crd, input logic [31:0] erd, input int len, input bit ill);
        vec_t v;
        v.op = o; v.init = init; v.exp_csr = ecsr; v.chk_rd = crd;
        v.exp_rd = erd; v.exp_len = len; v.exp_ill = ill;
        return v;
    endfunction

    function automatic cyc_t mkc(input logic [11:0] ra, input logic [11:0] wa, input logic [31:0] wd,
                                 input logic [4:0] rw, input logic [31:0] rdd, input logic dn, input logic il);
        cyc_t c;
        c.raddr = ra; c.waddr = wa; c.wdata = wd; c.rdw = rw; c.rdd = rdd; c.dn = dn; c.il = il;
        return c;
    endfunction

    // Expected per-cycle output trace of one op, from the Zicsr semantics.
    task automatic model(input op_t o);
        logic [31:0] src, old, nv;
        bit wr, ill, fast;
        src  = o.f3[2] ? {27'h0, o.rs1} : o.rs1_data;
        old  = (o.addr == 12'hFFF) ? 32'h0 : csr_mem[o.addr];
        wr   = (o.f3[1:0] == 2'b01) || (o.rs1 != 5'd0);
        ill  = wr && (o.addr >= 12'hC00);
        case (o.f3[1:0])
            2'b01:   nv = src;
            2'b10:   nv = old | src;
            default: nv = old & ~src;
        endcase
        fast = 1'b0;
`ifdef CSR_RMW_FASTWR_EN
        fast = (o.f3[1:0] == 2'b01) && (o.rd == 5'd0);
`endif
        exp_q.delete();
        if (fast) begin
            exp_q.push_back(mkc(12'hFFF, ill ? 12'hFFF : o.addr, ill ? 32'h0 : nv, 5'd0, 32'h0, 1'b1, ill));
        end else begin
            exp_q.push_back(mkc(o.addr, 12'hFFF, 32'h0, 5'd0, 32'h0, ill || (!wr && o.rd == 5'd0), ill));
            if (!ill) begin
                if (wr)
                    exp_q.push_back(mkc(12'hFFF, o.addr, nv, 5'd0, 32'h0, o.rd == 5'd0, 1'b0));
                if (o.rd != 5'd0)
                    exp_q.push_back(mkc(12'hFFF, 12'hFFF, 32'h0, o.rd, old, 1'b1, 1'b0));
            end
        end
    endtask

    task automatic drive(input op_t o, input logic v);
        req_valid    = v;
        req_funct3   = o.f3;
        req_csr_addr = o.addr;
        req_rs1_addr = o.rs1;
        req_rs1_data = o.rs1_data;
        req_rd_addr  = o.rd;
    endtask

    // Called and returns at a negedge with the DUT idle.
    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // Called at a negedge with the DUT expected idle; ends one negedge after done.
    task automatic issue(input op_t o, input bit chain, input op_t nxt,
                         output int got_len, output bit got_ill);
        cyc_t c;
        chk("idle_ready", 32'(req_ready), 32'd1);
        chk("idle_csr_waddr", 32'(csr_waddr), 32'hFFF);
        chk("idle_rd_waddr", 32'(rd_waddr), 32'd0);
        model(o);
        drive(o, 1'b1);
        got_len = 99;
        got_ill = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin
                if (chain) drive(nxt, 1'b1);
                else req_valid = 1'b0;
            end
            c = exp_q[i];
            chk("busy_ready", 32'(req_ready), 32'd0);
            chk("csr_raddr", 32'(csr_raddr), 32'(c.raddr));
            chk("csr_waddr", 32'(csr_waddr), 32'(c.waddr));
            chk("csr_wdata", csr_wdata, c.wdata);
            chk("rd_waddr", 32'(rd_waddr), 32'(c.rdw));
            chk("rd_wdata", rd_wdata, c.rdd);
            chk("done", 32'(done), 32'(c.dn));
            chk("illegal", 32'(illegal), 32'(c.il));
            if (done && got_len == 99) begin
                got_len = i + 1;
                got_ill = illegal;
            end
        end
        @(negedge clk);
    endtask

    vec_t tbl[12];
    op_t  none_op;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   len;
        bit   ill;
        op_t  o, o2;
        logic [2:0]  f3s [6];
        logic [11:0] adrs [10];

        f3s  = '{F3_RW, F3_RS, F3_RC, F3_RWI, F3_RSI, F3_RCI};
        adrs = '{12'h340, 12'h300, 12'h305, 12'h341, 12'hF11, 12'hC00, 12'hC01, 12'h7C0, 12'hB00, 12'hF14};

        tbl[0]  = mk(mkop(F3_RW,  12'h340, 5'd5, 32'hDEADBEEF, 5'd6), 32'h11, 32'hDEADBEEF, 1, 32'h11, 3, 0);
        tbl[1]  = mk(mkop(F3_RS,  12'h300, 5'd1, 32'h8, 5'd2), 32'h1800, 32'h1808, 1, 32'h1800, 3, 0);
        tbl[2]  = mk(mkop(F3_RC,  12'h300, 5'd1, 32'h8, 5'd2), 32'h1800, 32'h1800, 1, 32'h1800, 3, 0);
        tbl[3]  = mk(mkop(F3_RS,  12'hF11, 5'd0, 32'h0, 5'd7), 32'h013109F5, 32'h013109F5, 1, 32'h013109F5, 2, 0);
        tbl[4]  = mk(mkop(F3_RW,  12'hF11, 5'd5, 32'h1234, 5'd3), 32'h013109F5, 32'h013109F5, 0, 32'h0, 1, 1);
        tbl[5]  = mk(mkop(F3_RSI, 12'h340, 5'd0, 32'hFFFF_FFFF, 5'd0), 32'h55, 32'h55, 0, 32'h0, 1, 0);
`ifdef CSR_RMW_FASTWR_EN
        tbl[6]  = mk(mkop(F3_RWI, 12'h305, 5'd4, 32'hA5A5A5A5, 5'd0), 32'h0, 32'h4, 0, 32'h0, 1, 0);
`else
        tbl[6]  = mk(mkop(F3_RWI, 12'h305, 5'd4, 32'hA5A5A5A5, 5'd0), 32'h0, 32'h4, 0, 32'h0, 2, 0);
`endif
        tbl[7]  = mk(mkop(F3_RCI, 12'h300, 5'd31, 32'h1234_5678, 5'd4), 32'hFFFF, 32'hFFE0, 1, 32'hFFFF, 3, 0);
        tbl[8]  = mk(mkop(F3_RSI, 12'h340, 5'd3, 32'h0, 5'd0), 32'h10, 32'h13, 0, 32'h0, 2, 0);
        tbl[9]  = mk(mkop(F3_RC,  12'h340, 5'd0, 32'hFFFF_FFFF, 5'd8), 32'hAA, 32'hAA, 1, 32'hAA, 2, 0);
        tbl[10] = mk(mkop(F3_RW,  12'hC00, 5'd2, 32'h9, 5'd0), 32'h77, 32'h77, 0, 32'h0, 1, 1);
        tbl[11] = mk(mkop(F3_RS,  12'hC00, 5'd0, 32'h9, 5'd9), 32'h77, 32'h77, 1, 32'h77, 2, 0);

        none_op = mkop(3'b000, 12'h000, 5'd0, 32'h0, 5'd0);
        rst = 1'b1; rf_clr = 1'b1; pre_en = 1'b0; pre_addr = 12'h0; pre_data = 32'h0;
        drive(none_op, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_csr_raddr", 32'(csr_raddr), 32'hFFF);
        chk("rst_csr_waddr", 32'(csr_waddr), 32'hFFF);
        chk("rst_csr_wdata", csr_wdata, 32'h0);
        chk("rst_rd_waddr", 32'(rd_waddr), 32'd0);
        chk("rst_rd_wdata", rd_wdata, 32'h0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        rst = 1'b0; rf_clr = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) begin
            preload(tbl[i].op.addr, tbl[i].init);
            issue(tbl[i].op, 1'b0, none_op, len, ill);
            chk($sformatf("vec%0d_len", i), 32'(len), 32'(tbl[i].exp_len));
            chk($sformatf("vec%0d_ill", i), 32'(ill), 32'(tbl[i].exp_ill));
            chk($sformatf("vec%0d_csr", i), csr_mem[tbl[i].op.addr], tbl[i].exp_csr);
            if (tbl[i].chk_rd)
                chk($sformatf("vec%0d_rd", i), rf[tbl[i].op.rd], tbl[i].exp_rd);
        end

        // Back-to-back: second op is held valid while the first is busy.
        preload(12'h340, 32'h1);
        o  = mkop(F3_RW, 12'h340, 5'd5, 32'hCAFE0001, 5'd6);
        o2 = mkop(F3_RS, 12'h340, 5'd0, 32'h0, 5'd10);
        issue(o, 1'b1, o2, len, ill);
        chk("b2b_first_len", 32'(len), 32'd3);
        issue(o2, 1'b0, none_op, len, ill);
        chk("b2b_second_len", 32'(len), 32'd2);
        chk("b2b_second_rd", rf[10], 32'hCAFE0001);

        // Reset while in WCSR abandons the op before the rd write.
        preload(12'h340, 32'h99);
        drive(mkop(F3_RW, 12'h340, 5'd5, 32'h5A, 5'd11), 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstmid_read_raddr", 32'(csr_raddr), 32'h340);
        @(negedge clk);
        chk("rstmid_wcsr_waddr", 32'(csr_waddr), 32'h340);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_after_waddr", 32'(csr_waddr), 32'hFFF);
        chk("rstmid_after_rdw", 32'(rd_waddr), 32'd0);
        chk("rstmid_after_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_idle_rdw", 32'(rd_waddr), 32'd0);
        chk("rstmid_idle_done", 32'(done), 32'd0);
        chk("rstmid_rf11", rf[11], 32'h0);

        for (int k = 0; k < 250; k++) begin
            o.f3       = f3s[$urandom_range(0, 5)];
            o.addr     = adrs[$urandom_range(0, 9)];
            o.rs1      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            o.rd       = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            o.rs1_data = $urandom;
            preload(o.addr, $urandom);
            issue(o, 1'b0, none_op, len, ill);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
